hoop_field_mover: RTL and testbench

Parametrised multi-hoop motion engine for the power-up layer. Tracks `NUM_HOOPS` falling hoops in 6-bit fixed point. Services them one per cycle after each `startOfFrame` through a small sequencer. Handles respawn above the screen with pseudo-random X, horizontal wrap, collision push-off, pause and selectable fall speed. It feeds the hoop draw/collision logic with per-hoop top-left coordinates.

---
 rtl/hoop_pkg.sv | 45 ++++
 rtl/hoop_field_mover_offset_gen.sv | 43 ++++
 rtl/hoop_field_mover.sv | 162 ++++++++++++++++
 tb/tb_hoop_field_mover.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hoop_pkg.sv
// Shared types and constants for the hoop motion engine: fixed-point
// helpers, the fixed respawn offset table and the sequencer state type.
package hoop_pkg;

  localparam int FRAC_BITS_DEF    = 6;
  localparam int POS_W            = 32;
  localparam int PIX_W            = 11;
  localparam int OFFSET_W         = 9;
  localparam int OFFSET_TABLE_LEN = 10;

  // One hoop's motion state: fixed-point position plus sticky collision flag.
  typedef struct packed {
    logic signed [POS_W-1:0] x;
    logic signed [POS_W-1:0] y;
    logic                    col;
  } hoop_state_t;

  typedef enum logic [0:0] {
    SEQ_IDLE,
    SEQ_SERVICE
  } seq_state_t;

  // Pixel count to fixed-point units.
  function automatic logic signed [POS_W-1:0] pix_to_fix(input int pix, input int frac);
    return pix * (1 << frac);
  endfunction

  // Round-robin respawn offsets used when the LFSR source is not built in.
  function automatic logic [OFFSET_W-1:0] offset_table(input logic [3:0] idx);
    case (idx)
      4'd0:    return 9'd6;
      4'd1:    return 9'd500;
      4'd2:    return 9'd80;
      4'd3:    return 9'd100;
      4'd4:    return 9'd140;
      4'd5:    return 9'd18;
      4'd6:    return 9'd44;
      4'd7:    return 9'd340;
      4'd8:    return 9'd210;
      4'd9:    return 9'd277;
      default: return 9'd0;
    endcase
  endfunction

endpackage

// File: rtl/hoop_field_mover_offset_gen.sv
// Respawn X offset source shared by all hoops. Steps once per advance strobe.
// Build option HOOP_LFSR_EN: offset = low 9 bits of a 16-bit Galois LFSR
// (taps 16,14,13,11); otherwise a round-robin walk of the fixed table.
module hoop_offset_gen
  import hoop_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                advance,
  output logic [OFFSET_W-1:0] offset
);

`ifdef HOOP_LFSR_EN
  logic [15:0] lfsr;

  // Right-shifting Galois LFSR; feedback mask encodes taps 16,14,13,11.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else if (advance) begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign offset = lfsr[OFFSET_W-1:0];
`else
  logic [3:0] tbl_idx;

  // Table index walks 0..9 and wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      tbl_idx <= 4'd0;
    end else if (advance) begin
      tbl_idx <= (tbl_idx == 4'(OFFSET_TABLE_LEN - 1)) ? 4'd0 : tbl_idx + 4'd1;
    end
  end

  assign offset = offset_table(tbl_idx);
`endif

endmodule

// File: rtl/hoop_field_mover.sv
// Multi-hoop fall engine. After each startOfFrame a sequencer services one
// hoop per cycle: respawn above the screen, fall, horizontal wrap and
// collision push-off. Optional macro HOOP_LFSR_EN selects the LFSR offset
// source inside hoop_offset_gen.
module hoop_field_mover
  import hoop_pkg::*;
#(
  parameter int          NUM_HOOPS       = 4,
  parameter int          FRAC_BITS       = FRAC_BITS_DEF,
  parameter int          FALL_SPEED      = 100,
  parameter int          SCREEN_W        = 640,
  parameter int          SCREEN_H        = 480,
  parameter int          OBJECT_WIDTH_X  = 28,
  parameter int          OBJECT_HEIGHT_Y = 58,
  parameter int          COLLISION_NUDGE = 30,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         startOfFrame,
  input  logic                         pause,
  input  logic [1:0]                   speedLevel,
  input  logic [10:0]                  spawnX,
  input  logic [NUM_HOOPS-1:0]         towerHoopCollision,
  output logic [NUM_HOOPS*PIX_W-1:0]   topLeftX,
  output logic [NUM_HOOPS*PIX_W-1:0]   topLeftY,
  output logic [NUM_HOOPS-1:0]         respawnPulse,
  output logic                         frameDone
);

  localparam int IDX_W = (NUM_HOOPS > 1) ? $clog2(NUM_HOOPS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_HOOPS - 1);

  localparam logic signed [POS_W-1:0] RESPAWN_Y = pix_to_fix(-4 * OBJECT_HEIGHT_Y, FRAC_BITS);
  localparam logic signed [POS_W-1:0] WRAP_FIX  = pix_to_fix(SCREEN_W, FRAC_BITS);
  localparam logic signed [POS_W-1:0] PUSH_FIX  = pix_to_fix(OBJECT_WIDTH_X + COLLISION_NUDGE, FRAC_BITS);

  seq_state_t              state, state_next;
  logic [IDX_W-1:0]        idx, idx_next;
  logic                    capture;
  logic                    done_next;
  logic                    frame_pause;
  logic [1:0]              frame_speed;
  logic signed [POS_W-1:0] fall_step;
  logic signed [POS_W-1:0] spawn_fix;
  logic [OFFSET_W-1:0]     offset;
  logic [NUM_HOOPS-1:0]    respawn_fire;
  logic                    advance;

  // Sequencer state, service index and frameDone pulse register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SEQ_IDLE;
      idx       <= '0;
      frameDone <= 1'b0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      frameDone <= done_next;
    end
  end

  // Next-state logic: startOfFrame only matters in IDLE, so pulses during a pass are dropped.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    capture    = 1'b0;
    done_next  = 1'b0;
    case (state)
      SEQ_IDLE: begin
        if (startOfFrame) begin
          capture    = 1'b1;
          idx_next   = '0;
          state_next = SEQ_SERVICE;
        end
      end
      SEQ_SERVICE: begin
        if (idx == LAST_IDX) begin
          done_next  = 1'b1;
          state_next = SEQ_IDLE;
        end else begin
          idx_next = idx + 1'b1;
        end
      end
      default: state_next = SEQ_IDLE;
    endcase
  end

  // Pause and speed are frozen for the whole pass at frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_pause <= 1'b0;
      frame_speed <= 2'd0;
    end else if (capture) begin
      frame_pause <= pause;
      frame_speed <= speedLevel;
    end
  end

  assign fall_step = FALL_SPEED * (int'(frame_speed) + 1);
  assign spawn_fix = (32'(spawnX) + 32'(offset)) << FRAC_BITS;
  assign advance   = |respawn_fire;

  hoop_offset_gen #(
    .LFSR_SEED (LFSR_SEED)
  ) u_offset_gen (
    .clk     (clk),
    .reset   (reset),
    .advance (advance),
    .offset  (offset)
  );

  for (genvar gi = 0; gi < NUM_HOOPS; gi++) begin : g_hoop
    localparam logic signed [POS_W-1:0] RESET_Y = pix_to_fix(-4 * OBJECT_HEIGHT_Y * (gi + 1), FRAC_BITS);

    hoop_state_t             hoop_reg, hoop_next;
    logic                    pulse_reg, pulse_next;
    logic                    serviced;
    logic signed [POS_W-1:0] x_pix, y_pix;
    logic signed [POS_W-1:0] x_wrapped;

    assign serviced = (state == SEQ_SERVICE) && (idx == IDX_W'(gi));
    assign x_pix    = hoop_reg.x >>> FRAC_BITS;
    assign y_pix    = hoop_reg.y >>> FRAC_BITS;
    assign x_wrapped = (x_pix > SCREEN_W) ? hoop_reg.x - WRAP_FIX : hoop_reg.x;
    assign respawn_fire[gi] = serviced && !frame_pause && (y_pix > SCREEN_H);

    // Per-hoop update; the collision flag is sticky between services and a strobe in the service cycle survives.
    always_comb begin
      hoop_next     = hoop_reg;
      hoop_next.col = hoop_reg.col | towerHoopCollision[gi];
      pulse_next    = 1'b0;
      if (serviced && !frame_pause) begin
        hoop_next.col = towerHoopCollision[gi];
        if (y_pix > SCREEN_H) begin
          hoop_next.y = RESPAWN_Y;
          hoop_next.x = spawn_fix;
          pulse_next  = 1'b1;
        end else begin
          hoop_next.y = hoop_reg.y + fall_step;
          hoop_next.x = hoop_reg.col ? x_wrapped + PUSH_FIX : x_wrapped;
        end
      end
    end

    // Hoop state register with staggered reset heights.
    always_ff @(posedge clk) begin
      if (reset) begin
        hoop_reg  <= '{x: '0, y: RESET_Y, col: 1'b0};
        pulse_reg <= 1'b0;
      end else begin
        hoop_reg  <= hoop_next;
        pulse_reg <= pulse_next;
      end
    end

    assign topLeftX[gi*PIX_W +: PIX_W] = hoop_reg.x[FRAC_BITS +: PIX_W];
    assign topLeftY[gi*PIX_W +: PIX_W] = hoop_reg.y[FRAC_BITS +: PIX_W];
    assign respawnPulse[gi]            = pulse_reg;
  end

endmodule

// File: tb/tb_hoop_field_mover.sv
// Self-checking bench for hoop_field_mover: a frame-level model of the hoop
// rules is compared against every output on every cycle, plus hand-computed
// literal expectations for reset, first fall, respawn, wrap/push and pause.
module tb_hoop_field_mover;

  localparam int N    = 4;
  localparam int FRAC = 6;

  logic            clk = 1'b0;
  logic            reset;
  logic            startOfFrame;
  logic            pause;
  logic [1:0]      speedLevel;
  logic [10:0]     spawnX;
  logic [N-1:0]    towerHoopCollision;
  logic [N*11-1:0] topLeftX;
  logic [N*11-1:0] topLeftY;
  logic [N-1:0]    respawnPulse;
  logic            frameDone;

  always #5 clk = ~clk;

  hoop_field_mover #(
    .NUM_HOOPS       (N),
    .FRAC_BITS       (FRAC),
    .FALL_SPEED      (100),
    .SCREEN_W        (640),
    .SCREEN_H        (480),
    .OBJECT_WIDTH_X  (28),
    .OBJECT_HEIGHT_Y (58),
    .COLLISION_NUDGE (30),
    .LFSR_SEED       (16'hACE1)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .startOfFrame       (startOfFrame),
    .pause              (pause),
    .speedLevel         (speedLevel),
    .spawnX             (spawnX),
    .towerHoopCollision (towerHoopCollision),
    .topLeftX           (topLeftX),
    .topLeftY           (topLeftY),
    .respawnPulse       (respawnPulse),
    .frameDone          (frameDone)
  );

  localparam int OFFS [10] = '{6, 500, 80, 100, 140, 18, 44, 340, 210, 277};

  int       checks = 0;
  int       errors = 0;
  bit       chk_en = 1'b0;
  int       frame_no = 0;

  // Model state: fixed-point positions (pixels * 64) and collision flags.
  int       mx [N];
  int       my [N];
  bit       mcol [N];
  int       resp_count [N];
  int       f_pause;
  int       f_speed;
  int       off_idx;
  logic [15:0] m_lfsr;
  logic [N-1:0] exp_resp;
  logic     exp_done;

  int       save_y0;
  int       save_py0;

  function automatic int pix11(input int fix);
    int p;
    logic signed [10:0] t;
    p = fix >>> FRAC;
    t = p[10:0];
    return int'(t);
  endfunction

  function automatic int lane(input logic [N*11-1:0] v, input int i);
    logic signed [10:0] t;
    t = v[i*11 +: 11];
    return int'(t);
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  function automatic int next_offset();
    int o;
`ifdef HOOP_LFSR_EN
    logic lsb;
    o = int'(m_lfsr[8:0]);
    lsb = m_lfsr[0];
    m_lfsr = m_lfsr >> 1;
    if (lsb) m_lfsr = m_lfsr ^ 16'hB400;
`else
    o = OFFS[off_idx];
    off_idx = (off_idx + 1) % 10;
`endif
    return o;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i]   = 0;
      my[i]   = -(232 * (i + 1)) * 64;
      mcol[i] = 1'b0;
    end
    off_idx  = 0;
    m_lfsr   = 16'hACE1;
    exp_resp = '0;
    exp_done = 1'b0;
  endtask

  // Apply the per-hoop rules for one service of hoop i.
  task automatic model_service(input int i);
    exp_resp = '0;
    exp_done = (i == N - 1);
    if (f_pause == 0) begin
      if ((my[i] >>> FRAC) > 480) begin
        my[i] = -232 * 64;
        mx[i] = (int'(spawnX) + next_offset()) * 64;
        mcol[i] = 1'b0;
        exp_resp[i] = 1'b1;
        resp_count[i]++;
      end else begin
        my[i] = my[i] + 100 * (f_speed + 1);
        if ((mx[i] >>> FRAC) > 640) mx[i] = mx[i] - 640 * 64;
        if (mcol[i]) mx[i] = mx[i] + 58 * 64;
        mcol[i] = 1'b0;
      end
    end
  endtask

  // Compare every output against the model.
  task automatic compare();
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("x%0d", i), lane(topLeftX, i), pix11(mx[i]));
        check($sformatf("y%0d", i), lane(topLeftY, i), pix11(my[i]));
      end
      check("respawnPulse", int'(respawnPulse), int'(exp_resp));
      check("frameDone", int'(frameDone), int'(exp_done));
    end
  endtask

  // One clock: compare at the falling edge, then return just after the rising edge.
  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int extra_at);
    startOfFrame = 1'b1;
    f_pause = int'(pause);
    f_speed = int'(speedLevel);
    step();
    startOfFrame = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i == extra_at) startOfFrame = 1'b1;
      step();
      startOfFrame = 1'b0;
      model_service(i);
    end
    step();
    exp_resp = '0;
    exp_done = 1'b0;
    frame_no++;
    $display("frame %0d: hoop0 x=%0d y=%0d hoop1 x=%0d y=%0d", frame_no,
             lane(topLeftX, 0), lane(topLeftY, 0), lane(topLeftX, 1), lane(topLeftY, 1));
  endtask

  task automatic strobe(input int i);
    towerHoopCollision[i] = 1'b1;
    step();
    mcol[i] = 1'b1;
    towerHoopCollision = '0;
  endtask

  initial begin
    reset = 1'b1;
    startOfFrame = 1'b0;
    pause = 1'b0;
    speedLevel = 2'd0;
    spawnX = 11'd100;
    towerHoopCollision = '0;
    for (int i = 0; i < N; i++) resp_count[i] = 0;
    step();
    step();
    model_reset();
    chk_en = 1'b1;
    reset = 1'b0;

    // Reset state, idle with no frames.
    repeat (3) step();
    check("rst_y0", lane(topLeftY, 0), -232);
    check("rst_y1", lane(topLeftY, 1), -464);
    check("rst_x0", lane(topLeftX, 0), 0);
    check("rst_x3", lane(topLeftX, 3), 0);

    // First frame at speed 0.
    frame(-1);
    check("f1_y0", lane(topLeftY, 0), -231);
    check("f1_y1", lane(topLeftY, 1), -463);

    // Fall fast until hoop0 respawns.
    speedLevel = 2'd3;
    for (int f = 0; f < 300 && resp_count[0] == 0; f++) frame(-1);
    check("resp0_seen", resp_count[0], 1);
    check("resp0_x", lane(topLeftX, 0), 106);
    check("resp0_y", lane(topLeftY, 0), -232);

    // Next respawn (hoop1) takes offset 500: 141+500 = 641.
    spawnX = 11'd141;
    for (int f = 0; f < 300 && resp_count[1] == 0; f++) frame(-1);
    check("resp1_seen", resp_count[1], 1);
    check("resp1_x", lane(topLeftX, 1), 641);

    // Wrap 641 -> 1 then push-off +58 -> 59; flag cleared afterwards.
    strobe(1);
    frame(-1);
    check("wrap_push_x1", lane(topLeftX, 1), 59);
    frame(-1);
    check("col_clear_x1", lane(topLeftX, 1), 59);

    // Pause across three frames with a pending collision.
    strobe(0);
    pause = 1'b1;
    save_y0 = my[0];
    save_py0 = pix11(my[0]);
    repeat (3) frame(-1);
    check("pause_x0", lane(topLeftX, 0), 106);
    check("pause_y0", lane(topLeftY, 0), save_py0);
    pause = 1'b0;
    frame(-1);
    check("unpause_x0", lane(topLeftX, 0), 164);
    check("unpause_y0", lane(topLeftY, 0), pix11(save_y0 + 400));

    // Second startOfFrame during SERVICE must not start another pass.
    frame(1);
    repeat (6) step();

    // Reset while idx==2, with a stray startOfFrame in the pass.
    startOfFrame = 1'b1;
    f_pause = int'(pause);
    f_speed = int'(speedLevel);
    step();
    startOfFrame = 1'b0;
    step();
    model_service(0);
    startOfFrame = 1'b1;
    step();
    model_service(1);
    startOfFrame = 1'b0;
    reset = 1'b1;
    step();
    model_reset();
    reset = 1'b0;
    repeat (4) step();
    check("rst2_y0", lane(topLeftY, 0), -232);
    check("rst2_y1", lane(topLeftY, 1), -464);
    check("rst2_x0", lane(topLeftX, 0), 0);
    check("rst2_x1", lane(topLeftX, 1), 0);

    // Normal frame after reset.
    speedLevel = 2'd1;
    frame(-1);
    check("post_y0", lane(topLeftY, 0), -229);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
